// File: rtl/axi_pkg.sv
// Shared AXI encodings and helpers for the axi_bram slave.
package axi_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [2:0] AXI_SIZE_4B = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WRITE_RESP,
      ST_READ_ISSUE,
      ST_READ_DATA
   } bram_state_e;

   // Encodings happen to rank by severity: DECERR > SLVERR > OKAY.
   function automatic logic [1:0] worst_resp(
      input logic [1:0] a,
      input logic [1:0] b
   );
      return (a > b) ? a : b;
   endfunction

   function automatic logic burst_illegal(
      input logic [1:0] burst,
      input logic [2:0] size
   );
      return (burst != AXI_BURST_INCR) || (size != AXI_SIZE_4B);
   endfunction

endpackage

// File: rtl/axi_bram_if.sv
// AXI4 bus bundle between a master and the axi_bram slave.
interface axi_bram_if #(
   parameter int ADDR_WIDTH = 34,
   parameter int ID_WIDTH   = 1
);
   logic                  axi_awvalid;
   logic                  axi_awready;
   logic [ADDR_WIDTH-1:0] axi_awaddr;
   logic [7:0]            axi_awlen;
   logic [1:0]            axi_awburst;
   logic [2:0]            axi_awsize;
   logic [ID_WIDTH-1:0]   axi_awid;
   logic                  axi_awlock;
   logic [2:0]            axi_awprot;
   logic                  axi_wvalid;
   logic                  axi_wready;
   logic [31:0]           axi_wdata;
   logic [3:0]            axi_wstrb;
   logic                  axi_wlast;
   logic                  axi_bvalid;
   logic                  axi_bready;
   logic [1:0]            axi_bresp;
   logic [ID_WIDTH-1:0]   axi_bid;
   logic                  axi_arvalid;
   logic                  axi_arready;
   logic [ADDR_WIDTH-1:0] axi_araddr;
   logic [7:0]            axi_arlen;
   logic [1:0]            axi_arburst;
   logic [2:0]            axi_arsize;
   logic [ID_WIDTH-1:0]   axi_arid;
   logic                  axi_arlock;
   logic [2:0]            axi_arprot;
   logic                  axi_rvalid;
   logic                  axi_rready;
   logic [31:0]           axi_rdata;
   logic [1:0]            axi_rresp;
   logic                  axi_rlast;
   logic [ID_WIDTH-1:0]   axi_rid;

   modport master (
      output axi_awvalid, axi_awaddr, axi_awlen, axi_awburst,
      output axi_awsize, axi_awid, axi_awlock, axi_awprot,
      input  axi_awready,
      output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      input  axi_wready,
      input  axi_bvalid, axi_bresp, axi_bid,
      output axi_bready,
      output axi_arvalid, axi_araddr, axi_arlen, axi_arburst,
      output axi_arsize, axi_arid, axi_arlock, axi_arprot,
      input  axi_arready,
      input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
      output axi_rready
   );

   modport slave (
      input  axi_awvalid, axi_awaddr, axi_awlen, axi_awburst,
      input  axi_awsize, axi_awid, axi_awlock, axi_awprot,
      output axi_awready,
      input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      output axi_wready,
      output axi_bvalid, axi_bresp, axi_bid,
      input  axi_bready,
      input  axi_arvalid, axi_araddr, axi_arlen, axi_arburst,
      input  axi_arsize, axi_arid, axi_arlock, axi_arprot,
      output axi_arready,
      output axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
      input  axi_rready
   );

endinterface

// File: rtl/axi_bram_bram_1rw_be.sv
// Single-port DEPTH x 32 RAM with byte enables and registered read data.
module bram_1rw_be #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Array contents are deliberately left without reset.
   always_ff @(posedge clk) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
         if (i_we == 4'h0) begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_bram.sv
// AXI4 slave serving one INCR burst at a time from a byte-writable BRAM.
module axi_bram
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 34,
   parameter int ID_WIDTH   = 1,
   parameter int DEPTH      = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   axi_bram_if.slave  s_axi
);

   localparam int WW = ADDR_WIDTH - 2;
   localparam int AW = $clog2(DEPTH);
   localparam logic [WW-1:0] LP_DEPTH = WW'(DEPTH);

   bram_state_e         r_state;
   bram_state_e         w_next;
   logic [WW-1:0]       r_addr;
   logic [7:0]          r_len;
   logic [7:0]          r_cnt;
   logic [ID_WIDTH-1:0] r_id;
   logic                r_illegal;
   logic [1:0]          r_bresp;

   logic [1:0]  w_beat_resp;
   logic        w_beat_ok;
   logic        w_last_beat;
   logic        w_aw_hs;
   logic        w_ar_hs;
   logic        w_w_hs;
   logic        w_r_hs;
   logic [1:0]  w_wlast_resp;
   logic        w_mem_en;
   logic [3:0]  w_mem_we;
   logic [31:0] w_mem_q;
   logic        w_unused;

   assign w_beat_resp = r_illegal           ? AXI_RESP_SLVERR :
                        (r_addr >= LP_DEPTH) ? AXI_RESP_DECERR :
                                               AXI_RESP_OKAY;
   assign w_beat_ok   = (w_beat_resp == AXI_RESP_OKAY);
   assign w_last_beat = (r_cnt == r_len);

   assign w_aw_hs = s_axi.axi_awvalid & s_axi.axi_awready;
   assign w_ar_hs = s_axi.axi_arvalid & s_axi.axi_arready;
   assign w_w_hs  = s_axi.axi_wvalid  & s_axi.axi_wready;
   assign w_r_hs  = s_axi.axi_rvalid  & s_axi.axi_rready;

   assign w_wlast_resp = (s_axi.axi_wlast != w_last_beat) ?
                         AXI_RESP_SLVERR : AXI_RESP_OKAY;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // rst_n gates IDLE readiness so nothing handshakes while reset is held.
   always_comb begin
      w_next              = r_state;
      s_axi.axi_awready   = 1'b0;
      s_axi.axi_arready   = 1'b0;
      s_axi.axi_wready    = 1'b0;
      s_axi.axi_bvalid    = 1'b0;
      s_axi.axi_bresp     = AXI_RESP_OKAY;
      s_axi.axi_bid       = '0;
      s_axi.axi_rvalid    = 1'b0;
      s_axi.axi_rdata     = 32'h0;
      s_axi.axi_rresp     = AXI_RESP_OKAY;
      s_axi.axi_rlast     = 1'b0;
      s_axi.axi_rid       = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (rst_n && s_axi.axi_awvalid) begin
               s_axi.axi_awready = 1'b1;
               w_next            = ST_WRITE;
            end else if (rst_n && s_axi.axi_arvalid) begin
               s_axi.axi_arready = 1'b1;
               w_next            = ST_READ_ISSUE;
            end
         end
         ST_WRITE: begin
            s_axi.axi_wready = 1'b1;
            if (s_axi.axi_wvalid && w_last_beat) begin
               w_next = ST_WRITE_RESP;
            end
         end
         ST_WRITE_RESP: begin
            s_axi.axi_bvalid = 1'b1;
            s_axi.axi_bresp  = r_bresp;
            s_axi.axi_bid    = r_id;
            if (s_axi.axi_bready) begin
               w_next = ST_IDLE;
            end
         end
         ST_READ_ISSUE: begin
            w_next = ST_READ_DATA;
         end
         ST_READ_DATA: begin
            s_axi.axi_rvalid = 1'b1;
            s_axi.axi_rdata  = w_beat_ok ? w_mem_q : 32'h0;
            s_axi.axi_rresp  = w_beat_resp;
            s_axi.axi_rlast  = w_last_beat;
            s_axi.axi_rid    = r_id;
            if (s_axi.axi_rready) begin
               w_next = w_last_beat ? ST_IDLE : ST_READ_ISSUE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_len     <= 8'h0;
         r_cnt     <= 8'h0;
         r_id      <= '0;
         r_illegal <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
      end else if (w_aw_hs) begin
         r_addr    <= s_axi.axi_awaddr[ADDR_WIDTH-1:2];
         r_len     <= s_axi.axi_awlen;
         r_cnt     <= 8'h0;
         r_id      <= s_axi.axi_awid;
         r_illegal <= burst_illegal(s_axi.axi_awburst, s_axi.axi_awsize);
         r_bresp   <= AXI_RESP_OKAY;
      end else if (w_ar_hs) begin
         r_addr    <= s_axi.axi_araddr[ADDR_WIDTH-1:2];
         r_len     <= s_axi.axi_arlen;
         r_cnt     <= 8'h0;
         r_id      <= s_axi.axi_arid;
         r_illegal <= burst_illegal(s_axi.axi_arburst, s_axi.axi_arsize);
      end else if (w_w_hs) begin
         r_cnt   <= r_cnt + 8'd1;
         r_addr  <= r_addr + 1'b1;
         r_bresp <= worst_resp(r_bresp,
                               worst_resp(w_beat_resp, w_wlast_resp));
      end else if (w_r_hs && !w_last_beat) begin
         r_cnt  <= r_cnt + 8'd1;
         r_addr <= r_addr + 1'b1;
      end
   end

   assign w_mem_we = (w_w_hs && w_beat_ok) ? s_axi.axi_wstrb : 4'h0;
   assign w_mem_en = (w_w_hs && w_beat_ok) || (r_state == ST_READ_ISSUE);

   bram_1rw_be #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_en    (w_mem_en),
      .i_we    (w_mem_we),
      .i_addr  (r_addr[AW-1:0]),
      .i_wdata (s_axi.axi_wdata),
      .o_rdata (w_mem_q)
   );

   assign w_unused = ^{s_axi.axi_awaddr[1:0], s_axi.axi_araddr[1:0],
                       s_axi.axi_awlock, s_axi.axi_awprot,
                       s_axi.axi_arlock, s_axi.axi_arprot};

endmodule

// File: tb/tb_axi_bram.sv
// Directed bench for axi_bram: reset, strobes, bursts, errors, ordering.
module tb_axi_bram;
   import axi_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   axi_bram_if #(.ADDR_WIDTH(34), .ID_WIDTH(1)) bus ();

   axi_bram #(
      .ADDR_WIDTH (34),
      .ID_WIDTH   (1),
      .DEPTH      (1024)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_axi (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic put_aw(input logic [33:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic id);
      bus.axi_awvalid = 1'b1;
      bus.axi_awaddr  = a;
      bus.axi_awlen   = len;
      bus.axi_awburst = burst;
      bus.axi_awsize  = AXI_SIZE_4B;
      bus.axi_awid    = id;
      #1;
      for (int n = 0; n < 20 && !bus.axi_awready; n++) step();
      chk("aw_ready", bus.axi_awready, 1);
      step();
      bus.axi_awvalid = 1'b0;
   endtask

   task automatic put_ar(input logic [33:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic id);
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = a;
      bus.axi_arlen   = len;
      bus.axi_arburst = burst;
      bus.axi_arsize  = AXI_SIZE_4B;
      bus.axi_arid    = id;
      #1;
      for (int n = 0; n < 20 && !bus.axi_arready; n++) step();
      chk("ar_ready", bus.axi_arready, 1);
      step();
      bus.axi_arvalid = 1'b0;
   endtask

   task automatic put_w(input logic [31:0] d, input logic [3:0] s,
                        input logic last);
      bus.axi_wvalid = 1'b1;
      bus.axi_wdata  = d;
      bus.axi_wstrb  = s;
      bus.axi_wlast  = last;
      #1;
      for (int n = 0; n < 20 && !bus.axi_wready; n++) step();
      chk("w_ready", bus.axi_wready, 1);
      step();
      bus.axi_wvalid = 1'b0;
   endtask

   task automatic get_b(input logic [1:0] resp, input logic id,
                        input string tag);
      bus.axi_bready = 1'b1;
      #1;
      for (int n = 0; n < 20 && !bus.axi_bvalid; n++) step();
      chk({tag, "_bvalid"}, bus.axi_bvalid, 1);
      chk({tag, "_bresp"}, bus.axi_bresp, resp);
      chk({tag, "_bid"}, bus.axi_bid, id);
      step();
      bus.axi_bready = 1'b0;
   endtask

   task automatic get_r(input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic id,
                        input string tag);
      bus.axi_rready = 1'b1;
      #1;
      for (int n = 0; n < 20 && !bus.axi_rvalid; n++) step();
      chk({tag, "_rvalid"}, bus.axi_rvalid, 1);
      chk({tag, "_rdata"}, bus.axi_rdata, d);
      chk({tag, "_rresp"}, bus.axi_rresp, resp);
      chk({tag, "_rlast"}, bus.axi_rlast, last);
      chk({tag, "_rid"}, bus.axi_rid, id);
      step();
      bus.axi_rready = 1'b0;
      chk({tag, "_bubble"}, bus.axi_rvalid, 0);
   endtask

   initial begin
      bus.axi_awvalid = 1'b0;
      bus.axi_awaddr  = '0;
      bus.axi_awlen   = 8'h0;
      bus.axi_awburst = AXI_BURST_INCR;
      bus.axi_awsize  = AXI_SIZE_4B;
      bus.axi_awid    = 1'b0;
      bus.axi_awlock  = 1'b0;
      bus.axi_awprot  = 3'h0;
      bus.axi_wvalid  = 1'b0;
      bus.axi_wdata   = 32'h0;
      bus.axi_wstrb   = 4'h0;
      bus.axi_wlast   = 1'b0;
      bus.axi_bready  = 1'b0;
      bus.axi_arvalid = 1'b0;
      bus.axi_araddr  = '0;
      bus.axi_arlen   = 8'h0;
      bus.axi_arburst = AXI_BURST_INCR;
      bus.axi_arsize  = AXI_SIZE_4B;
      bus.axi_arid    = 1'b0;
      bus.axi_arlock  = 1'b0;
      bus.axi_arprot  = 3'h0;
      bus.axi_rready  = 1'b0;

      // Reset held with both address channels requesting addr 0.
      bus.axi_awvalid = 1'b1;
      bus.axi_arvalid = 1'b1;
      repeat (3) step();
      chk("rst_awready", bus.axi_awready, 0);
      chk("rst_arready", bus.axi_arready, 0);
      chk("rst_wready", bus.axi_wready, 0);
      chk("rst_bvalid", bus.axi_bvalid, 0);
      chk("rst_rvalid", bus.axi_rvalid, 0);
      chk("rst_rlast", bus.axi_rlast, 0);
      chk("rst_bresp", bus.axi_bresp, 0);
      chk("rst_rresp", bus.axi_rresp, 0);

      rst_n = 1'b1;
      #1;
      chk("rel_awready", bus.axi_awready, 1);
      chk("rel_arready", bus.axi_arready, 0);
      step();
      bus.axi_awvalid = 1'b0;
      #1;
      chk("wr_arready", bus.axi_arready, 0);
      put_w(32'hFF00FF00, 4'hF, 1'b1);
      chk("b_latency", bus.axi_bvalid, 1);
      get_b(AXI_RESP_OKAY, 1'b0, "single");

      chk("ar_after_w", bus.axi_arready, 1);
      step();
      bus.axi_arvalid = 1'b0;
      chk("r_lat1", bus.axi_rvalid, 0);
      step();
      chk("r_lat2", bus.axi_rvalid, 1);
      get_r(32'hFF00FF00, AXI_RESP_OKAY, 1'b1, 1'b0, "single_r");

      // Byte strobes merge into the existing word.
      put_aw(34'h8, 8'd0, AXI_BURST_INCR, 1'b0);
      put_w(32'hDEADBEEF, 4'hF, 1'b1);
      get_b(AXI_RESP_OKAY, 1'b0, "bs1");
      put_aw(34'h8, 8'd0, AXI_BURST_INCR, 1'b0);
      put_w(32'h11223344, 4'b0101, 1'b1);
      get_b(AXI_RESP_OKAY, 1'b0, "bs2");
      put_ar(34'h8, 8'd0, AXI_BURST_INCR, 1'b0);
      get_r(32'hDE22BE44, AXI_RESP_OKAY, 1'b1, 1'b0, "bs_r");

      // Four-beat burst with backpressure on beat 2.
      put_aw(34'h10, 8'd3, AXI_BURST_INCR, 1'b1);
      put_w(32'd1, 4'hF, 1'b0);
      put_w(32'd2, 4'hF, 1'b0);
      put_w(32'd3, 4'hF, 1'b0);
      put_w(32'd4, 4'hF, 1'b1);
      get_b(AXI_RESP_OKAY, 1'b1, "burst");
      put_ar(34'h10, 8'd3, AXI_BURST_INCR, 1'b1);
      get_r(32'd1, AXI_RESP_OKAY, 1'b0, 1'b1, "burst_r0");
      for (int n = 0; n < 20 && !bus.axi_rvalid; n++) step();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_rvalid", bus.axi_rvalid, 1);
         chk("hold_rdata", bus.axi_rdata, 32'd2);
         chk("hold_rlast", bus.axi_rlast, 0);
      end
      get_r(32'd2, AXI_RESP_OKAY, 1'b0, 1'b1, "burst_r1");
      get_r(32'd3, AXI_RESP_OKAY, 1'b0, 1'b1, "burst_r2");
      get_r(32'd4, AXI_RESP_OKAY, 1'b1, 1'b1, "burst_r3");

      // Word index DEPTH is out of range and must not alias word 0.
      put_aw(34'h1000, 8'd0, AXI_BURST_INCR, 1'b0);
      put_w(32'hCAFEBABE, 4'hF, 1'b1);
      get_b(AXI_RESP_DECERR, 1'b0, "oor");
      put_ar(34'h0, 8'd0, AXI_BURST_INCR, 1'b0);
      get_r(32'hFF00FF00, AXI_RESP_OKAY, 1'b1, 1'b0, "oor_mem");
      put_ar(34'h1000, 8'd0, AXI_BURST_INCR, 1'b0);
      get_r(32'h0, AXI_RESP_DECERR, 1'b1, 1'b0, "oor_r");

      put_ar(34'h10, 8'd1, AXI_BURST_WRAP, 1'b0);
      get_r(32'h0, AXI_RESP_SLVERR, 1'b0, 1'b0, "wrap_r0");
      get_r(32'h0, AXI_RESP_SLVERR, 1'b1, 1'b0, "wrap_r1");

      put_aw(34'h10, 8'd0, AXI_BURST_WRAP, 1'b0);
      put_w(32'h99, 4'hF, 1'b1);
      get_b(AXI_RESP_SLVERR, 1'b0, "wrap_w");
      put_ar(34'h10, 8'd0, AXI_BURST_INCR, 1'b0);
      get_r(32'd1, AXI_RESP_OKAY, 1'b1, 1'b0, "wrap_mem");

      put_aw(34'h20, 8'd1, AXI_BURST_INCR, 1'b0);
      put_w(32'hA, 4'hF, 1'b1);
      put_w(32'hB, 4'hF, 1'b1);
      get_b(AXI_RESP_SLVERR, 1'b0, "early");

      // Simultaneous AW/AR: write wins, read sees the new data.
      bus.axi_awvalid = 1'b1;
      bus.axi_awaddr  = 34'h40;
      bus.axi_awlen   = 8'd0;
      bus.axi_awburst = AXI_BURST_INCR;
      bus.axi_awid    = 1'b1;
      bus.axi_arvalid = 1'b1;
      bus.axi_araddr  = 34'h40;
      bus.axi_arlen   = 8'd0;
      bus.axi_arburst = AXI_BURST_INCR;
      bus.axi_arid    = 1'b1;
      #1;
      chk("sim_awready", bus.axi_awready, 1);
      chk("sim_arready", bus.axi_arready, 0);
      step();
      bus.axi_awvalid = 1'b0;
      put_w(32'h5A5A1234, 4'hF, 1'b1);
      get_b(AXI_RESP_OKAY, 1'b1, "sim");
      for (int n = 0; n < 20 && !bus.axi_arready; n++) step();
      chk("sim_ar", bus.axi_arready, 1);
      step();
      bus.axi_arvalid = 1'b0;
      get_r(32'h5A5A1234, AXI_RESP_OKAY, 1'b1, 1'b1, "sim_r");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
